product_bcd_converter: RTL

PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

---
 rtl/alu_pkg.sv | 16 +
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/product_bcd_converter.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the product-to-BCD converter.
//   state_t           : converter FSM states
//   BLANK_DIGIT       : code driven on a blanked display digit
//   BCD_ADJ_THRESHOLD : double-dabble nibble value that triggers the +3 adjust
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_DIGIT       = 4'hF;
    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble nibble correction: adds 3 when the nibble is 5 or more.
// Ports:
//   digit    in  4  BCD nibble before the shift
//   adjusted out 4  nibble after the conditional +3 (no carry out)
module bcd_digit_adjust
    import alu_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= BCD_ADJ_THRESHOLD) ? digit + 4'd3 : digit;

endmodule

// File: rtl/product_bcd_converter.sv
// Converts an unsigned product (up to 63) into two BCD digits with a
// serial double-dabble, one bit per cycle, behind valid/ready handshakes.
// Build option: define PRODUCT_BCD_BLANK_EN to show a zero tens digit as
// the blank code BLANK_DIGIT.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   in_valid    product_in is valid            in_ready  ready to accept (IDLE)
//   product_in  binary product (IN_WIDTH bits)
//   out_valid   digits hold a result (DONE)     out_ready downstream consumes
//   tens_out    BCD tens digit                  ones_out  BCD ones digit
//
// state | meaning
// IDLE  | waiting for a product, in_ready=1
// SHIFT | one double-dabble step per cycle, IN_WIDTH steps total
// DONE  | result presented, waiting for out_ready
module product_bcd_converter
    import alu_pkg::*;
#(
    parameter int IN_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] product_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          tens_out,
    output logic [3:0]          ones_out
);

    localparam int FW = IN_WIDTH + 8;
    localparam logic [2:0] LAST_SHIFT = 3'(IN_WIDTH - 1);

    state_t         state;
    logic [2:0]     cnt;
    // {tens nibble, ones nibble, remaining binary bits}
    logic [FW-1:0]  field;
    logic [3:0]     tens_adj;
    logic [3:0]     ones_adj;
    logic [FW-1:0]  shifted;
    logic [3:0]     tens_disp;

    bcd_digit_adjust u_adj_tens (
        .digit    (field[FW-1 -: 4]),
        .adjusted (tens_adj)
    );

    bcd_digit_adjust u_adj_ones (
        .digit    (field[FW-5 -: 4]),
        .adjusted (ones_adj)
    );

    assign shifted = {tens_adj, ones_adj, field[IN_WIDTH-1:0]} << 1;

`ifdef PRODUCT_BCD_BLANK_EN
    assign tens_disp = (shifted[FW-1 -: 4] == 4'd0) ? BLANK_DIGIT : shifted[FW-1 -: 4];
`else
    assign tens_disp = shifted[FW-1 -: 4];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            field     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            tens_out  <= 4'd0;
            ones_out  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        field    <= {8'd0, product_in};
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    field <= shifted;
                    cnt   <= cnt + 3'd1;
                    // Digits are taken from the final shift so they update
                    // on the same edge that raises out_valid.
                    if (cnt == LAST_SHIFT) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        tens_out  <= tens_disp;
                        ones_out  <= shifted[FW-5 -: 4];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
